cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 132 +++++++++++++
 tb/tb_cdb_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers functional-unit completions in a FIFO
// and broadcasts up to WAYS of them per cycle in acceptance order.

`ifndef WAYS
`define WAYS 2
`endif
`ifndef ROB
`define ROB 32
`endif
`ifndef PRF
`define PRF 64
`endif
`ifndef XLEN
`define XLEN 32
`endif

module cdb_arbiter #(
    parameter int NUM_FU = 4,
    parameter int DEPTH  = 8
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   proc_nuke,
    input  logic [NUM_FU-1:0]                      fu_valid,
    input  logic [NUM_FU-1:0][$clog2(`ROB)-1:0]    fu_ROB_idx,
    input  logic [NUM_FU-1:0][$clog2(`PRF)-1:0]    fu_PRN,
    input  logic [NUM_FU-1:0][`XLEN-1:0]           fu_value,
    input  logic [NUM_FU-1:0]                      fu_direction,
    input  logic [NUM_FU-1:0][`XLEN-1:0]           fu_target,
    output logic [NUM_FU-1:0]                      fu_ready,
    output logic [`WAYS-1:0]                       CDB_valid,
    output logic [`WAYS-1:0][$clog2(`ROB)-1:0]     CDB_ROB_idx,
    output logic [`WAYS-1:0][$clog2(`PRF)-1:0]     CDB_PRN,
    output logic [`WAYS-1:0][`XLEN-1:0]            CDB_value,
    output logic [`WAYS-1:0]                       CDB_direction,
    output logic [`WAYS-1:0][`XLEN-1:0]            CDB_target,
    output logic [$clog2(DEPTH):0]                 num_free_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = $clog2(`ROB);
    localparam int PW = $clog2(`PRF);
    localparam int XW = `XLEN;
    localparam int W  = `WAYS;

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic [CW-1:0] n_acc;
    logic [CW-1:0] pop_k;
    logic [CW-1:0] pre;
    logic [CW-1:0] off [NUM_FU];
    logic          flush;

    logic [RW-1:0] mem_rob [DEPTH];
    logic [PW-1:0] mem_prn [DEPTH];
    logic [XW-1:0] mem_val [DEPTH];
    logic          mem_dir [DEPTH];
    logic [XW-1:0] mem_tgt [DEPTH];

    assign flush        = reset | proc_nuke;
    assign free         = CW'(DEPTH) - count;
    assign num_free_out = free;
    assign pop_k        = (count > CW'(W)) ? CW'(W) : count;

    // Admission: lower FU index claims free slots first; room comes only
    // from registered occupancy, never from this cycle's pops.
    always_comb begin
        pre      = '0;
        n_acc    = '0;
        fu_ready = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            off[i]      = pre;
            fu_ready[i] = !flush && (pre < free);
            if (fu_valid[i]) begin
                if (fu_ready[i]) begin
                    n_acc = n_acc + CW'(1);
                end
                pre = pre + CW'(1);
            end
        end
    end

    // Broadcast the oldest min(WAYS, count) entries, lane i = head + i.
    always_comb begin
        CDB_valid     = '0;
        CDB_ROB_idx   = '0;
        CDB_PRN       = '0;
        CDB_value     = '0;
        CDB_direction = '0;
        CDB_target    = '0;
        for (int l = 0; l < W; l++) begin
            if (!flush && (CW'(l) < count)) begin
                CDB_valid[l]     = 1'b1;
                CDB_ROB_idx[l]   = mem_rob[head + AW'(l)];
                CDB_PRN[l]       = mem_prn[head + AW'(l)];
                CDB_value[l]     = mem_val[head + AW'(l)];
                CDB_direction[l] = mem_dir[head + AW'(l)];
                CDB_target[l]    = mem_tgt[head + AW'(l)];
            end
        end
    end

    // Store accepted results at consecutive slots from tail.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (fu_valid[i] && fu_ready[i]) begin
                mem_rob[tail + AW'(off[i])] <= fu_ROB_idx[i];
                mem_prn[tail + AW'(off[i])] <= fu_PRN[i];
                mem_val[tail + AW'(off[i])] <= fu_value[i];
                mem_dir[tail + AW'(off[i])] <= fu_direction[i];
                mem_tgt[tail + AW'(off[i])] <= fu_target[i];
            end
        end
    end

    // Pointer and occupancy update; reset and flush both empty the FIFO.
    always_ff @(posedge clock) begin
        if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(pop_k);
            tail  <= tail + AW'(n_acc);
            count <= count + n_acc - pop_k;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a reference model predicts ready,
// broadcast lanes and free count each cycle.

`ifndef WAYS
`define WAYS 2
`endif
`ifndef ROB
`define ROB 32
`endif
`ifndef PRF
`define PRF 64
`endif
`ifndef XLEN
`define XLEN 32
`endif

module tb_cdb_arbiter;

    localparam int NFU   = 4;
    localparam int DEPTH = 8;
    localparam int W     = `WAYS;
    localparam int RW    = $clog2(`ROB);
    localparam int PW    = $clog2(`PRF);
    localparam int XW    = `XLEN;

    typedef struct packed {
        logic          v;
        logic [RW-1:0] rob;
        logic [PW-1:0] prn;
        logic [XW-1:0] val;
        logic          dir;
        logic [XW-1:0] tgt;
    } lane_t;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     proc_nuke;
    logic [NFU-1:0]           fu_valid;
    logic [NFU-1:0][RW-1:0]   fu_ROB_idx;
    logic [NFU-1:0][PW-1:0]   fu_PRN;
    logic [NFU-1:0][XW-1:0]   fu_value;
    logic [NFU-1:0]           fu_direction;
    logic [NFU-1:0][XW-1:0]   fu_target;
    logic [NFU-1:0]           fu_ready;
    logic [W-1:0]             CDB_valid;
    logic [W-1:0][RW-1:0]     CDB_ROB_idx;
    logic [W-1:0][PW-1:0]     CDB_PRN;
    logic [W-1:0][XW-1:0]     CDB_value;
    logic [W-1:0]             CDB_direction;
    logic [W-1:0][XW-1:0]     CDB_target;
    logic [3:0]               num_free_out;

    cdb_arbiter #(.NUM_FU(NFU), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .proc_nuke(proc_nuke),
        .fu_valid(fu_valid), .fu_ROB_idx(fu_ROB_idx), .fu_PRN(fu_PRN),
        .fu_value(fu_value), .fu_direction(fu_direction),
        .fu_target(fu_target), .fu_ready(fu_ready),
        .CDB_valid(CDB_valid), .CDB_ROB_idx(CDB_ROB_idx),
        .CDB_PRN(CDB_PRN), .CDB_value(CDB_value),
        .CDB_direction(CDB_direction), .CDB_target(CDB_target),
        .num_free_out(num_free_out)
    );

    always #5 clock = ~clock;

    lane_t          pend [NFU];
    logic [NFU-1:0] pv;
    lane_t          sb [$];
    logic           drv_reset;
    logic           drv_nuke;
    logic [NFU-1:0] obs_ready, exp_ready;
    lane_t [W-1:0]  obs_cdb, exp_cdb;
    logic [3:0]     obs_free, exp_free;
    int             vectors = 0;
    int             errors  = 0;
    int             seq     = 1;

    function automatic lane_t mk(int s);
        lane_t e;
        e.v   = 1'b1;
        e.rob = RW'(s);
        e.prn = PW'(s * 3 + 1);
        e.val = XW'(32'hA500_0000 + s);
        e.dir = s[0];
        e.tgt = XW'(32'h0000_1000 + s * 4);
        return e;
    endfunction

    task automatic load(int i);
        pend[i] = mk(seq);
        seq++;
        pv[i] = 1'b1;
    endtask

    // Drive one cycle, snapshot DUT outputs, predict them, advance the model.
    task automatic tick();
        int pre;
        int free;
        int k;
        for (int i = 0; i < NFU; i++) begin
            fu_valid[i]     = pv[i];
            fu_ROB_idx[i]   = pend[i].rob;
            fu_PRN[i]       = pend[i].prn;
            fu_value[i]     = pend[i].val;
            fu_direction[i] = pend[i].dir;
            fu_target[i]    = pend[i].tgt;
        end
        reset     = drv_reset;
        proc_nuke = drv_nuke;
        @(negedge clock);
        obs_ready = fu_ready;
        obs_free  = num_free_out;
        for (int l = 0; l < W; l++) begin
            obs_cdb[l] = {CDB_valid[l], CDB_ROB_idx[l], CDB_PRN[l],
                          CDB_value[l], CDB_direction[l], CDB_target[l]};
        end
        free     = DEPTH - sb.size();
        exp_free = 4'(free);
        pre      = 0;
        for (int i = 0; i < NFU; i++) begin
            exp_ready[i] = !drv_reset && !drv_nuke && (pre < free);
            if (pv[i]) pre++;
        end
        k = (sb.size() < W) ? sb.size() : W;
        for (int l = 0; l < W; l++) begin
            exp_cdb[l] = '0;
            if (!drv_reset && !drv_nuke && l < k) exp_cdb[l] = sb[l];
        end
        if (drv_reset || drv_nuke) begin
            sb.delete();
        end else begin
            for (int l = 0; l < k; l++) void'(sb.pop_front());
            for (int i = 0; i < NFU; i++) begin
                if (pv[i] && exp_ready[i]) begin
                    sb.push_back(pend[i]);
                    pv[i] = 1'b0;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        drv_reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if (obs_ready !== '0) begin
                errors++;
                $display("FAIL reset_ready: got %b want 0000", obs_ready);
            end
            vectors++;
            if (obs_cdb !== '0) begin
                errors++;
                $display("FAIL reset_cdb: got %h want 0", obs_cdb);
            end
        end
        drv_reset = 1'b0;
        tick();
        vectors++;
        if (obs_free !== 4'd8) begin
            errors++;
            $display("FAIL reset_free: got %0d want 8", obs_free);
        end
        vectors++;
        if (obs_cdb !== '0 || obs_ready !== 4'b1111) begin
            errors++;
            $display("FAIL reset_out: got cdb %h rdy %b want 0 1111",
                     obs_cdb, obs_ready);
        end
    endtask

    task automatic test_basic();
        load(0);
        pend[0].rob = 5'd3;
        load(2);
        pend[2].rob = 5'd7;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (obs_ready !== exp_ready) begin
                errors++;
                $display("FAIL basic_ready: got %b want %b", obs_ready, exp_ready);
            end
            vectors++;
            if (obs_cdb !== exp_cdb) begin
                errors++;
                $display("FAIL basic_cdb: got %h want %h", obs_cdb, exp_cdb);
            end
            vectors++;
            if (obs_free !== exp_free) begin
                errors++;
                $display("FAIL basic_free: got %0d want %0d", obs_free, exp_free);
            end
            if (c == 1) begin
                vectors++;
                if ({obs_cdb[1].v, obs_cdb[0].v} !== 2'b11 ||
                    obs_cdb[0].rob !== 5'd3 || obs_cdb[1].rob !== 5'd7) begin
                    errors++;
                    $display("FAIL basic_lanes: got v%b%b idx %0d %0d want v11 idx 3 7",
                             obs_cdb[1].v, obs_cdb[0].v,
                             obs_cdb[0].rob, obs_cdb[1].rob);
                end
            end
            if (c == 2) begin
                vectors++;
                if ({obs_cdb[1].v, obs_cdb[0].v} !== 2'b00) begin
                    errors++;
                    $display("FAIL basic_idle: got v%b%b want v00",
                             obs_cdb[1].v, obs_cdb[0].v);
                end
            end
        end
    endtask

    task automatic test_fill();
        int c;
        for (c = 0; c < 3; c++) begin
            for (int i = 0; i < NFU; i++) if (!pv[i]) load(i);
            tick();
            vectors++;
            if (obs_ready !== exp_ready) begin
                errors++;
                $display("FAIL fill_ready: got %b want %b", obs_ready, exp_ready);
            end
            vectors++;
            if (obs_cdb !== exp_cdb) begin
                errors++;
                $display("FAIL fill_cdb: got %h want %h", obs_cdb, exp_cdb);
            end
            vectors++;
            if (obs_free !== exp_free) begin
                errors++;
                $display("FAIL fill_free: got %0d want %0d", obs_free, exp_free);
            end
            if (c == 2) begin
                vectors++;
                if (obs_ready !== 4'b0011) begin
                    errors++;
                    $display("FAIL fill_cycle2_ready: got %b want 0011", obs_ready);
                end
            end
        end
        for (c = 0; c < 20 && (pv != '0 || sb.size() != 0); c++) begin
            tick();
            vectors++;
            if (obs_cdb !== exp_cdb || obs_ready !== exp_ready) begin
                errors++;
                $display("FAIL fill_drain: got %h/%b want %h/%b",
                         obs_cdb, obs_ready, exp_cdb, exp_ready);
            end
        end
        tick();
        vectors++;
        if (pv != '0 || obs_free !== 4'd8 || obs_cdb !== '0) begin
            errors++;
            $display("FAIL fill_empty: got free %0d cdb %h pend %b want 8 0 0000",
                     obs_free, obs_cdb, pv);
        end
    endtask

    task automatic test_wrap();
        for (int c = 0; c < 20; c++) begin
            load(0);
            tick();
            vectors++;
            if (obs_cdb !== exp_cdb) begin
                errors++;
                $display("FAIL wrap_cdb: got %h want %h", obs_cdb, exp_cdb);
            end
            vectors++;
            if (obs_ready !== exp_ready || obs_free !== exp_free) begin
                errors++;
                $display("FAIL wrap_ctl: got %b/%0d want %b/%0d",
                         obs_ready, obs_free, exp_ready, exp_free);
            end
            if (c > 0) begin
                vectors++;
                if ({obs_cdb[1].v, obs_cdb[0].v} !== 2'b01) begin
                    errors++;
                    $display("FAIL wrap_lane0: got v%b%b want v01",
                             obs_cdb[1].v, obs_cdb[0].v);
                end
            end
        end
        tick();
        vectors++;
        if (obs_cdb !== exp_cdb) begin
            errors++;
            $display("FAIL wrap_last: got %h want %h", obs_cdb, exp_cdb);
        end
    endtask

    task automatic test_nuke();
        for (int i = 0; i < 4; i++) load(i);
        tick();
        for (int i = 0; i < 3; i++) load(i);
        tick();
        vectors++;
        if (obs_cdb !== exp_cdb) begin
            errors++;
            $display("FAIL nuke_pre: got %h want %h", obs_cdb, exp_cdb);
        end
        for (int i = 0; i < 4; i++) load(i);
        drv_nuke = 1'b1;
        tick();
        drv_nuke = 1'b0;
        vectors++;
        if (obs_ready !== 4'b0000 || obs_cdb !== '0) begin
            errors++;
            $display("FAIL nuke_cycle: got rdy %b cdb %h want 0000 0",
                     obs_ready, obs_cdb);
        end
        vectors++;
        if (obs_free !== 4'd3) begin
            errors++;
            $display("FAIL nuke_free_before: got %0d want 3", obs_free);
        end
        pv = '0;
        tick();
        vectors++;
        if (obs_free !== 4'd8 || obs_cdb !== '0) begin
            errors++;
            $display("FAIL nuke_after: got free %0d cdb %h want 8 0",
                     obs_free, obs_cdb);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) load(i);
        tick();
        for (int i = 0; i < 4; i++) load(i);
        tick();
        vectors++;
        if (obs_cdb !== exp_cdb || obs_free !== 4'd4) begin
            errors++;
            $display("FAIL rmid_pre: got %h/%0d want %h/4",
                     obs_cdb, obs_free, exp_cdb);
        end
        drv_reset = 1'b1;
        tick();
        drv_reset = 1'b0;
        vectors++;
        if (obs_free !== 4'd2 || obs_cdb !== '0 || obs_ready !== '0) begin
            errors++;
            $display("FAIL rmid_cycle: got free %0d cdb %h rdy %b want 2 0 0000",
                     obs_free, obs_cdb, obs_ready);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            vectors++;
            if (obs_free !== 4'd8 || obs_cdb !== '0) begin
                errors++;
                $display("FAIL rmid_stale: got free %0d cdb %h want 8 0",
                         obs_free, obs_cdb);
            end
        end
        load(1);
        tick();
        tick();
        vectors++;
        if (obs_cdb !== exp_cdb || obs_cdb[0].v !== 1'b1) begin
            errors++;
            $display("FAIL rmid_resume: got %h want %h", obs_cdb, exp_cdb);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        pv        = '0;
        drv_reset = 1'b1;
        drv_nuke  = 1'b0;
        for (int i = 0; i < NFU; i++) pend[i] = '0;
        test_reset();
        test_basic();
        test_fill();
        test_wrap();
        test_nuke();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
